fft_pingpong_mem: RTL and testbench
===================================

# fft_pingpong_mem

Parametrised two-bank ping-pong buffer for the radix-2 FFT datapath, sitting between the butterfly unit and its operand/result streams. Each bank is dual-ported; one bank is read by the butterfly while the other absorbs its results, with both ports active in the same cycle. The bank roles swap once per FFT stage under a built-in stage sequencer. The sequencer counts stages, flags the last stage and reports completion. Read data is registered and carries a valid flag.

## Interface
Parameters:
- DATA_W, 64, width of one stored word (complex sample, re/im packed)
- ADDR_W, 5, address width per bank; depth = 2**ADDR_W words per bank
- NUM_STAGES, 5, number of FFT stages (swaps) per transform; range 1..2**STAGE_W-1
- STAGE_W, 3, width of the stage counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a transform
- swap  in  1  one-cycle pulse marking the end of the current stage
- write_enable  in  1  writes din_1/din_2 into the current write bank
- addw_1, addw_2  in  ADDR_W  write addresses, ports 1/2
- din_1, din_2  in  DATA_W  write data, ports 1/2
- read_enable  in  1  issues reads on both ports
- addr_1, addr_2  in  ADDR_W  read addresses, ports 1/2
- dout_1, dout_2  out  DATA_W  registered read data
- rd_valid  out  1  dout_1/dout_2 hold data for a read issued at the read latency earlier
- select  out  1  current bank map: 1 = write A / read B; 0 = write B / read A
- stage  out  STAGE_W  index of the current stage, 0..NUM_STAGES-1
- last_stage  out  1  busy && stage == NUM_STAGES-1
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse on completion of the final stage

## Operation
- Bank map: when select=1, writes go to bank A and reads come from bank B. When select=0, writes go to bank B and reads come from bank A. The read bank and the write bank are never the same, so no read/write collision is possible.
- Writes are accepted regardless of busy. This allows the initial sample load before start.
- Same-cycle write to one address on both ports: port 2 data is stored.
- Sequencer states:
  - IDLE (busy=0): start → RUN with stage=0 and select=0.
  - RUN (busy=1): swap with stage<NUM_STAGES-1 → select toggles, stage+1.
  - RUN (busy=1): swap with stage==NUM_STAGES-1 → select toggles, stage→0, done pulses, return to IDLE.
- start while in RUN restarts the transform: stage=0, select=0, no done pulse.
- start and swap in the same cycle: start wins and swap is ignored.
- swap in IDLE is ignored; select, stage and done are unchanged.
- After done, select points the read bank at the final results. With NUM_STAGES odd and start→select=0, the final results are read from bank B.
- Reset values: select=0, stage=0, busy=0, last_stage=0, done=0, rd_valid=0, dout_1=dout_2=0. RAM contents are not reset.
- rst mid-transform aborts the transform and applies the reset values on the next edge. No done pulse is produced.

## Timing
- Write: data is stored at the clk edge where write_enable=1. The bank is chosen by the select value before that edge.
- Read: address and bank are sampled at the edge where read_enable=1, using the pre-edge select. The read latency is counted from that edge.
- A swap in the same cycle as a read or write does not affect that access. The access uses the old map, and the new map applies from the next cycle.
- A read of the bank just written by the previous stage, issued on the cycle after swap, returns the newly written data.
- rd_valid follows read_enable delayed by the read latency. dout holds its last value while rd_valid=0.
- done is asserted for exactly the one cycle after the final swap edge. busy falls on that same edge.

## Configuration
- FFT_PPMEM_OUTREG_EN defined: an extra output register stage is added. Read latency is 2 cycles, and rd_valid and dout are both delayed by 2.
- FFT_PPMEM_OUTREG_EN undefined: read latency is 1 cycle.
- The sequencer, write path and all reset values are identical in both builds.

## Test plan
- Reset: hold rst for 2 cycles → all outputs are 0, busy=0, select=0.
- Load, start, read (NUM_STAGES=5):
  - With select=0, write addw_1=3/din_1=0xA5, then pulse start.
  - Read from bank A is not the target: pulse swap once → select=1.
  - read addr_1=3 → dout_1=0xA5 with rd_valid at latency 1 (or 2 with FFT_PPMEM_OUTREG_EN).
- Full sequence: start, then 5 swaps spaced 10 cycles apart.
  - stage steps 0,1,2,3,4; last_stage is high only during stage 4.
  - done pulses once, busy falls, final select=1.
- Collision: write_enable with addw_1=addw_2=7, din_1=1, din_2=2 → a later read of 7 returns 2.
- Swap same-cycle: read addr_1=0 in the swap cycle → data comes from the old read bank. The next read of address 0 returns data from the other bank.
- Control corner cases:
  - start+swap together → stage=0 and select=0.
  - swap in IDLE → no change.
  - rst at stage 2 → busy=0, no done pulse.

Source files
------------

// File: rtl/fft_pingpong_mem_if.sv
// Operand/result bus between the FFT controller and the ping-pong buffer.
// master drives writes, reads and sequencer pulses; slave is the buffer.
interface fft_pingpong_mem_if #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int STAGE_W = 3
);
  logic                start;
  logic                swap;
  logic                write_enable;
  logic [ADDR_W-1:0]   addw_1;
  logic [ADDR_W-1:0]   addw_2;
  logic [DATA_W-1:0]   din_1;
  logic [DATA_W-1:0]   din_2;
  logic                read_enable;
  logic [ADDR_W-1:0]   addr_1;
  logic [ADDR_W-1:0]   addr_2;
  logic [DATA_W-1:0]   dout_1;
  logic [DATA_W-1:0]   dout_2;
  logic                rd_valid;
  logic                select;
  logic [STAGE_W-1:0]  stage;
  logic                last_stage;
  logic                busy;
  logic                done;

  modport master (
    output start, swap, write_enable, addw_1, addw_2, din_1, din_2,
           read_enable, addr_1, addr_2,
    input  dout_1, dout_2, rd_valid, select, stage, last_stage, busy, done
  );

  modport slave (
    input  start, swap, write_enable, addw_1, addw_2, din_1, din_2,
           read_enable, addr_1, addr_2,
    output dout_1, dout_2, rd_valid, select, stage, last_stage, busy, done
  );
endinterface

// File: rtl/fft_pingpong_mem.sv
// Two-bank ping-pong buffer with a built-in FFT stage sequencer.
// Define FFT_PPMEM_OUTREG_EN to add a second output register (read latency 2).
module fft_pingpong_mem #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3
) (
  input logic                clk,
  input logic                rst,
  fft_pingpong_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic                select_q, select_d;
  logic                done_q, done_d;
  logic                finalSwap;

  logic [DATA_W-1:0]   bankA [DEPTH];
  logic [DATA_W-1:0]   bankB [DEPTH];
  logic [DATA_W-1:0]   rdData1_q, rdData2_q;
  logic                rdValid_q;

  assign finalSwap = (state_q == RUN) && bus.swap && (stage_q == LAST_STAGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      select_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      select_q <= select_d;
      done_q   <= done_d;
    end
  end

  // start always wins over swap, including a restart from RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (!bus.start && finalSwap) state_d = IDLE;
    endcase
  end

  always_comb begin
    stage_d  = stage_q;
    select_d = select_q;
    done_d   = 1'b0;
    if (bus.start) begin
      stage_d  = '0;
      select_d = 1'b0;
    end else if ((state_q == RUN) && bus.swap) begin
      select_d = !select_q;
      if (finalSwap) begin
        stage_d = '0;
        done_d  = 1'b1;
      end else begin
        stage_d = stage_q + STAGE_W'(1);
      end
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.last_stage = (state_q == RUN) && (stage_q == LAST_STAGE);
  assign bus.select     = select_q;
  assign bus.stage      = stage_q;
  assign bus.done       = done_q;

  // Port 2 is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (bus.write_enable && select_q) begin
      bankA[bus.addw_1] <= bus.din_1;
      bankA[bus.addw_2] <= bus.din_2;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.write_enable && !select_q) begin
      bankB[bus.addw_1] <= bus.din_1;
      bankB[bus.addw_2] <= bus.din_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdValid_q <= 1'b0;
      rdData1_q <= '0;
      rdData2_q <= '0;
    end else begin
      rdValid_q <= bus.read_enable;
      if (bus.read_enable) begin
        rdData1_q <= select_q ? bankB[bus.addr_1] : bankA[bus.addr_1];
        rdData2_q <= select_q ? bankB[bus.addr_2] : bankA[bus.addr_2];
      end
    end
  end

`ifdef FFT_PPMEM_OUTREG_EN
  logic [DATA_W-1:0] outData1_q, outData2_q;
  logic              outValid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData1_q <= '0;
      outData2_q <= '0;
    end else begin
      outValid_q <= rdValid_q;
      if (rdValid_q) begin
        outData1_q <= rdData1_q;
        outData2_q <= rdData2_q;
      end
    end
  end

  assign bus.dout_1   = outData1_q;
  assign bus.dout_2   = outData2_q;
  assign bus.rd_valid = outValid_q;
`else
  assign bus.dout_1   = rdData1_q;
  assign bus.dout_2   = rdData2_q;
  assign bus.rd_valid = rdValid_q;
`endif

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// Self-checking bench for fft_pingpong_mem: directed corner cases plus a
// randomized run compared against a bank/sequencer reference model.
module tb_fft_pingpong_mem;

  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 5;
  localparam int NUM_STAGES = 5;
  localparam int STAGE_W    = 3;
  localparam int DEPTH      = 2 ** ADDR_W;
`ifdef FFT_PPMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit                v;
    bit                k1;
    bit                k2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } rd_entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_pingpong_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGE_W(STAGE_W)) bus ();

  fft_pingpong_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: two plain memories, the bank selector and stage count
  logic [DATA_W-1:0] memA [DEPTH];
  logic [DATA_W-1:0] memB [DEPTH];
  bit                knownA [DEPTH];
  bit                knownB [DEPTH];
  bit                mSel, mBusy, mDone, mValid, mK1, mK2;
  int                mStage;
  logic [DATA_W-1:0] mDout1, mDout2;
  rd_entry_t         pipe [$];

  task automatic model_edge();
    rd_entry_t e;
    if (rst) begin
      mSel = 0; mBusy = 0; mDone = 0; mStage = 0;
      mValid = 0; mDout1 = '0; mDout2 = '0; mK1 = 1; mK2 = 1;
      pipe.delete();
      for (int i = 0; i < LAT - 1; i++) pipe.push_back('{default: 0});
      return;
    end
    e = '{default: 0};
    e.v = bus.read_enable;
    if (bus.read_enable) begin
      if (mSel) begin
        e.d1 = memB[bus.addr_1]; e.k1 = knownB[bus.addr_1];
        e.d2 = memB[bus.addr_2]; e.k2 = knownB[bus.addr_2];
      end else begin
        e.d1 = memA[bus.addr_1]; e.k1 = knownA[bus.addr_1];
        e.d2 = memA[bus.addr_2]; e.k2 = knownA[bus.addr_2];
      end
    end
    if (bus.write_enable) begin
      if (mSel) begin
        memA[bus.addw_1] = bus.din_1; knownA[bus.addw_1] = 1;
        memA[bus.addw_2] = bus.din_2; knownA[bus.addw_2] = 1;
      end else begin
        memB[bus.addw_1] = bus.din_1; knownB[bus.addw_1] = 1;
        memB[bus.addw_2] = bus.din_2; knownB[bus.addw_2] = 1;
      end
    end
    mDone = 0;
    if (bus.start) begin
      mBusy = 1; mStage = 0; mSel = 0;
    end else if (bus.swap && mBusy) begin
      mSel = !mSel;
      if (mStage == NUM_STAGES - 1) begin
        mStage = 0; mBusy = 0; mDone = 1;
      end else begin
        mStage++;
      end
    end
    pipe.push_back(e);
    e = pipe.pop_front();
    mValid = e.v;
    if (e.v) begin
      mDout1 = e.d1; mK1 = e.k1;
      mDout2 = e.d2; mK2 = e.k2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.swap = 0; bus.write_enable = 0; bus.read_enable = 0;
    bus.addw_1 = '0; bus.addw_2 = '0; bus.din_1 = '0; bus.din_2 = '0;
    bus.addr_1 = '0; bus.addr_2 = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    total++;
    if ({bus.select, bus.stage, bus.busy, bus.last_stage, bus.done, bus.rd_valid} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got sel=%b stage=%0d busy=%b last=%b done=%b vld=%b exp all 0",
               bus.select, bus.stage, bus.busy, bus.last_stage, bus.done, bus.rd_valid);
    end
    total++;
    if (bus.dout_1 !== '0 || bus.dout_2 !== '0) begin
      bad++;
      $display("[TB] FAIL reset_dout got %h/%h exp 0/0", bus.dout_1, bus.dout_2);
    end
    rst = 0;
  endtask

  task automatic test_load_read();
    int lat;
    bus.write_enable = 1; bus.addw_1 = 3; bus.din_1 = 64'hA5;
    bus.addw_2 = 4; bus.din_2 = 64'h5A5A;
    tick();
    bus.write_enable = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    total++;
    if (bus.busy !== 1'b1 || bus.stage !== 3'd0 || bus.select !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_start got busy=%b stage=%0d sel=%b exp 1/0/0", bus.busy, bus.stage, bus.select);
    end
    bus.swap = 1;
    tick();
    bus.swap = 0;
    total++;
    if (bus.select !== 1'b1 || bus.stage !== 3'd1) begin
      bad++;
      $display("[TB] FAIL load_swap got sel=%b stage=%0d exp 1/1", bus.select, bus.stage);
    end
    bus.read_enable = 1; bus.addr_1 = 3; bus.addr_2 = 4;
    tick();
    bus.read_enable = 0;
    lat = 1;
    while (bus.rd_valid !== 1'b1 && lat < 5) begin
      tick();
      lat++;
    end
    total++;
    if (lat != LAT) begin
      bad++;
      $display("[TB] FAIL read_latency got %0d exp %0d", lat, LAT);
    end
    total++;
    if (bus.dout_1 !== 64'hA5 || bus.dout_2 !== 64'h5A5A) begin
      bad++;
      $display("[TB] FAIL load_read got %h/%h exp a5/5a5a", bus.dout_1, bus.dout_2);
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.dout_1 !== 64'hA5) begin
      bad++;
      $display("[TB] FAIL dout_hold got vld=%b d1=%h exp 0/a5", bus.rd_valid, bus.dout_1);
    end
  endtask

  task automatic test_full_sequence();
    int doneCount = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      for (int c = 0; c < 10; c++) begin
        total++;
        if (bus.stage !== STAGE_W'(s) || bus.last_stage !== (s == NUM_STAGES - 1) ||
            bus.busy !== 1'b1 || bus.select !== s[0]) begin
          bad++;
          $display("[TB] FAIL full_seq s=%0d c=%0d got stage=%0d last=%b busy=%b sel=%b exp stage=%0d last=%b busy=1 sel=%b",
                   s, c, bus.stage, bus.last_stage, bus.busy, bus.select, s, (s == NUM_STAGES - 1), s[0]);
        end
        if (bus.done === 1'b1) doneCount++;
        bus.swap = (c == 9);
        tick();
        bus.swap = 0;
      end
    end
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.select !== 1'b1 ||
        bus.stage !== 3'd0 || bus.last_stage !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_end got done=%b busy=%b sel=%b stage=%0d last=%b exp 1/0/1/0/0",
               bus.done, bus.busy, bus.select, bus.stage, bus.last_stage);
    end
    if (bus.done === 1'b1) doneCount++;
    repeat (3) begin
      tick();
      if (bus.done === 1'b1) doneCount++;
    end
    total++;
    if (doneCount != 1) begin
      bad++;
      $display("[TB] FAIL done_count got %0d exp 1", doneCount);
    end
  endtask

  task automatic test_collision();
    int lat;
    bus.start = 1;
    tick();
    bus.start = 0;
    bus.write_enable = 1; bus.addw_1 = 7; bus.addw_2 = 7; bus.din_1 = 64'd1; bus.din_2 = 64'd2;
    tick();
    bus.write_enable = 0;
    bus.swap = 1;
    tick();
    bus.swap = 0;
    bus.read_enable = 1; bus.addr_1 = 7; bus.addr_2 = 7;
    tick();
    bus.read_enable = 0;
    lat = 1;
    while (bus.rd_valid !== 1'b1 && lat < 5) begin
      tick();
      lat++;
    end
    total++;
    if (bus.rd_valid !== 1'b1 || bus.dout_1 !== 64'd2 || bus.dout_2 !== 64'd2) begin
      bad++;
      $display("[TB] FAIL collision got vld=%b d1=%0d d2=%0d exp 1/2/2", bus.rd_valid, bus.dout_1, bus.dout_2);
    end
  endtask

  task automatic test_swap_same_cycle();
    logic [DATA_W-1:0] got [$];
    bus.write_enable = 1; bus.addw_1 = 0; bus.din_1 = 64'h111; bus.addw_2 = 1; bus.din_2 = 64'h0;
    tick();
    bus.write_enable = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    bus.write_enable = 1; bus.addw_1 = 0; bus.din_1 = 64'h222; bus.addw_2 = 2; bus.din_2 = 64'h0;
    tick();
    bus.write_enable = 0;
    bus.read_enable = 1; bus.addr_1 = 0; bus.addr_2 = 0; bus.swap = 1;
    tick();
    bus.swap = 0;
    if (bus.rd_valid === 1'b1) got.push_back(bus.dout_1);
    tick();
    bus.read_enable = 0;
    if (bus.rd_valid === 1'b1) got.push_back(bus.dout_1);
    repeat (3) begin
      tick();
      if (bus.rd_valid === 1'b1) got.push_back(bus.dout_1);
    end
    total++;
    if (got.size() != 2 || got[0] !== 64'h111 || got[1] !== 64'h222) begin
      bad++;
      $display("[TB] FAIL swap_same_cycle got n=%0d first=%h second=%h exp n=2 111/222",
               got.size(), (got.size() > 0) ? got[0] : '0, (got.size() > 1) ? got[1] : '0);
    end
  endtask

  task automatic test_control();
    bus.start = 1; bus.swap = 1;
    tick();
    bus.start = 0; bus.swap = 0;
    total++;
    if (bus.stage !== 3'd0 || bus.select !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_swap got stage=%0d sel=%b busy=%b exp 0/0/1", bus.stage, bus.select, bus.busy);
    end
    bus.swap = 1;
    repeat (2) tick();
    bus.swap = 0;
    total++;
    if (bus.stage !== 3'd2) begin
      bad++;
      $display("[TB] FAIL pre_abort_stage got %0d exp 2", bus.stage);
    end
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (bus.busy !== 1'b0 || bus.stage !== 3'd0 || bus.select !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort got busy=%b stage=%0d sel=%b done=%b exp 0/0/0/0",
               bus.busy, bus.stage, bus.select, bus.done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL abort_no_done cycle=%0d got %b exp 0", i, bus.done);
      end
    end
    bus.start = 1;
    tick();
    bus.start = 0;
    bus.swap = 1;
    repeat (NUM_STAGES) tick();
    bus.swap = 0;
    total++;
    if (bus.busy !== 1'b0 || bus.select !== 1'b1 || bus.done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_swaps got busy=%b sel=%b done=%b exp 0/1/1", bus.busy, bus.select, bus.done);
    end
    bus.swap = 1;
    tick();
    bus.swap = 0;
    total++;
    if (bus.select !== 1'b1 || bus.stage !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_swap got sel=%b stage=%0d busy=%b done=%b exp 1/0/0/0",
               bus.select, bus.stage, bus.busy, bus.done);
    end
  endtask

  task automatic test_random();
    logic [7:0] obs, exp;
    for (int i = 0; i < 600; i++) begin
      bus.start        = ($urandom_range(59) == 0);
      bus.swap         = ($urandom_range(2) == 0);
      bus.write_enable = $urandom_range(1);
      bus.read_enable  = $urandom_range(1);
      bus.addw_1 = ADDR_W'($urandom); bus.addw_2 = ADDR_W'($urandom);
      bus.addr_1 = ADDR_W'($urandom); bus.addr_2 = ADDR_W'($urandom);
      bus.din_1  = {$urandom, $urandom};
      bus.din_2  = {$urandom, $urandom};
      tick();
      obs = {bus.select, bus.stage, bus.busy, bus.last_stage, bus.done, bus.rd_valid};
      exp = {mSel, STAGE_W'(mStage), mBusy, mBusy && (mStage == NUM_STAGES - 1), mDone, mValid};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL rand_ctrl cycle=%0d got %b exp %b (sel,stage,busy,last,done,vld)", i, obs, exp);
      end
      if (mK1 && mK2) begin
        total++;
        if (bus.dout_1 !== mDout1 || bus.dout_2 !== mDout2) begin
          bad++;
          $display("[TB] FAIL rand_dout cycle=%0d got %h/%h exp %h/%h", i, bus.dout_1, bus.dout_2, mDout1, mDout2);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_full_sequence();
    test_collision();
    test_swap_same_cycle();
    test_control();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
